// File: rtl/roulette_game_ctrl.sv
// roulette_game_ctrl: credit/bet bookkeeping and spin sequencing for the LED roulette spinner
module roulette_game_ctrl #(
  parameter int CREDIT_W      = 10,
  parameter int INIT_CREDIT   = 100,
  parameter int BET_UNIT      = 10,
  parameter int MAX_BET_UNITS = 9,
  parameter int PAYOUT_MULT   = 7,
  parameter int SHOW_CYCLES   = 100000000,
  parameter int SPIN_TIMEOUT  = 500000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_start,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [2:0]          bet_sel,
  input  logic                spin_done,
  input  logic [2:0]          result_pos,
  output logic                start_spin,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          bet_units,
  output logic [2:0]          locked_pos,
  output logic                win,
  output logic                lose,
  output logic                reject,
  output logic                err_timeout,
  output logic                game_over,
  output logic [2:0]          state_dbg
);
  localparam int CW = CREDIT_W + 4;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EVAL, S_SHOW, S_OVER} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [3:0] units_n;
  logic [2:0] locked_n, res_q, res_n;
  logic spin_n, win_n, lose_n, rej_n, err_n, over_n;
  logic [31:0] tcnt, tcnt_n, scnt, scnt_n;
  logic [CW-1:0] cost, credit_w, payout;
  // cost is only ever subtracted after cost <= credit, so its low bits refund exactly
  assign cost      = CW'(bet_units) * CW'(BET_UNIT);
  assign credit_w  = CW'(credit);
  assign payout    = credit_w + cost * CW'(PAYOUT_MULT);
  assign state_dbg = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= S_IDLE;
      credit      <= CREDIT_W'(INIT_CREDIT);
      bet_units   <= 4'd1;
      locked_pos  <= '0;
      res_q       <= '0;
      start_spin  <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      reject      <= 1'b0;
      err_timeout <= 1'b0;
      game_over   <= 1'b0;
      tcnt        <= '0;
      scnt        <= '0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      bet_units   <= units_n;
      locked_pos  <= locked_n;
      res_q       <= res_n;
      start_spin  <= spin_n;
      win         <= win_n;
      lose        <= lose_n;
      reject      <= rej_n;
      err_timeout <= err_n;
      game_over   <= over_n;
      tcnt        <= tcnt_n;
      scnt        <= scnt_n;
    end
  always_comb begin
    state_n  = state;
    credit_n = credit;
    units_n  = bet_units;
    locked_n = locked_pos;
    res_n    = res_q;
    spin_n   = 1'b0;
    win_n    = win;
    lose_n   = lose;
    rej_n    = 1'b0;
    err_n    = err_timeout;
    over_n   = game_over;
    tcnt_n   = tcnt;
    scnt_n   = scnt;
    case (state)
      S_IDLE:
        if (btn_start) begin
          if (cost <= credit_w) begin
            spin_n   = 1'b1;
            credit_n = credit - cost[CREDIT_W-1:0];
            locked_n = bet_sel;
            err_n    = 1'b0;
            tcnt_n   = '0;
            state_n  = S_WAIT;
          end else
            rej_n = 1'b1;
        end else if (btn_inc && !btn_dec && bet_units < 4'(MAX_BET_UNITS))
          units_n = bet_units + 4'd1;
        else if (btn_dec && !btn_inc && bet_units > 4'd1)
          units_n = bet_units - 4'd1;
      S_WAIT: begin
        tcnt_n = tcnt + 32'd1;
        if (spin_done) begin
          res_n   = result_pos;
          state_n = S_EVAL;
        end else if (tcnt == 32'(SPIN_TIMEOUT - 1)) begin
          credit_n = credit + cost[CREDIT_W-1:0];
          err_n    = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_EVAL: begin
        scnt_n  = '0;
        state_n = S_SHOW;
        win_n   = res_q == locked_pos;
        lose_n  = res_q != locked_pos;
        if (res_q == locked_pos)
          credit_n = payout > CW'(CREDIT_MAX) ? CREDIT_MAX : payout[CREDIT_W-1:0];
      end
      S_SHOW:
        if (scnt == 32'(SHOW_CYCLES - 1)) begin
          win_n   = 1'b0;
          lose_n  = 1'b0;
          over_n  = credit < CREDIT_W'(BET_UNIT);
          state_n = credit < CREDIT_W'(BET_UNIT) ? S_OVER : S_IDLE;
        end else
          scnt_n = scnt + 32'd1;
      S_OVER:
        if (btn_start) begin
          credit_n = CREDIT_W'(INIT_CREDIT);
          units_n  = 4'd1;
          over_n   = 1'b0;
          state_n  = S_IDLE;
        end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_roulette_game_ctrl.sv
// tb_roulette_game_ctrl: directed and randomized checks of roulette_game_ctrl against a round-level credit model
module tb_roulette_game_ctrl;
  localparam int T = 20, S = 8, MAXC = 1023;
  logic clk = 0, rst = 0;
  logic btn_start = 0, btn_inc = 0, btn_dec = 0, spin_done = 0;
  logic [2:0] bet_sel = 0, result_pos = 0;
  logic start_spin, win, lose, reject, err_timeout, game_over;
  logic [9:0] credit;
  logic [3:0] bet_units;
  logic [2:0] locked_pos, state_dbg;
  logic b8_start = 0, b8_done = 0;
  logic [2:0] b8_sel = 0, b8_res = 0;
  logic s8, w8, l8, r8, e8, g8;
  logic [7:0] c8;
  logic [3:0] u8;
  logic [2:0] lp8, st8;
  int n_chk = 0, n_fail = 0, m_credit = 100, m_units = 1, m_spins = 0, spins = 0;

  always #5 clk = ~clk;

  roulette_game_ctrl #(.SHOW_CYCLES(S), .SPIN_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .bet_sel(bet_sel), .spin_done(spin_done), .result_pos(result_pos), .start_spin(start_spin),
    .credit(credit), .bet_units(bet_units), .locked_pos(locked_pos), .win(win), .lose(lose),
    .reject(reject), .err_timeout(err_timeout), .game_over(game_over), .state_dbg(state_dbg));

  roulette_game_ctrl #(.CREDIT_W(8), .INIT_CREDIT(250), .SHOW_CYCLES(S), .SPIN_TIMEOUT(T)) dut8 (
    .clk(clk), .rst(rst), .btn_start(b8_start), .btn_inc(1'b0), .btn_dec(1'b0),
    .bet_sel(b8_sel), .spin_done(b8_done), .result_pos(b8_res), .start_spin(s8),
    .credit(c8), .bet_units(u8), .locked_pos(lp8), .win(w8), .lose(l8),
    .reject(r8), .err_timeout(e8), .game_over(g8), .state_dbg(st8));

  always @(negedge clk) if (start_spin) spins++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 1ms", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit s, input bit i, input bit d);
    btn_start = s; btn_inc = i; btn_dec = d;
    tick;
    btn_start = 0; btn_inc = 0; btn_dec = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    repeat (2) tick;
    rst = 0;
    tick;
    m_credit = 100;
    m_units = 1;
  endtask

  task automatic model_btn(input bit i, input bit d);
    if (i && !d) m_units = m_units < 9 ? m_units + 1 : 9;
    if (d && !i) m_units = m_units > 1 ? m_units - 1 : 1;
  endtask

  // One accepted bet; delay > T means the spinner never answers
  task automatic play(input logic [2:0] sel, input logic [2:0] res, input int delay, input bit i, input bit d);
    int cost;
    bit won, ok;
    cost = m_units * 10;
    bet_sel = sel;
    press(1, i, d);
    bet_sel = 3'($urandom);
    m_credit -= cost;
    m_spins++;
    n_chk++;
    if ({start_spin, err_timeout, state_dbg} !== {1'b1, 1'b0, 3'd1} || credit !== 10'(m_credit)
        || locked_pos !== sel || bet_units !== 4'(m_units)) begin
      n_fail++;
      $display("FAIL launch: spin=%b err=%b st=%0d credit=%0d units=%0d pos=%0d, required 1 0 1 %0d %0d %0d",
               start_spin, err_timeout, state_dbg, credit, bet_units, locked_pos, m_credit, m_units, sel);
    end
    if (delay > T) begin
      ok = 1;
      repeat (T - 1) begin
        tick;
        if (state_dbg !== 3'd1 || credit !== 10'(m_credit) || start_spin !== 1'b0) ok = 0;
      end
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL wait_hold: st=%0d credit=%0d spin=%b, required 1 %0d 0", state_dbg, credit, start_spin, m_credit);
      end
      tick;
      m_credit += cost;
      n_chk++;
      if (state_dbg !== 3'd0 || credit !== 10'(m_credit) || err_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout: st=%0d credit=%0d err=%b, required 0 %0d 1", state_dbg, credit, err_timeout, m_credit);
      end
    end else begin
      ok = 1;
      repeat (delay - 1) begin
        tick;
        if (state_dbg !== 3'd1 || start_spin !== 1'b0) ok = 0;
      end
      spin_done = 1;
      result_pos = res;
      tick;
      spin_done = 0;
      result_pos = 3'($urandom);
      n_chk++;
      if (!ok || state_dbg !== 3'd2) begin
        n_fail++;
        $display("FAIL to_eval: st=%0d wait_ok=%b, required 2 1", state_dbg, ok);
      end
      tick;
      won = res == sel;
      if (won) m_credit = m_credit + cost * 7 > MAXC ? MAXC : m_credit + cost * 7;
      n_chk++;
      if (credit !== 10'(m_credit) || win !== won || lose !== !won || state_dbg !== 3'd3) begin
        n_fail++;
        $display("FAIL eval: credit=%0d win=%b lose=%b st=%0d, required %0d %b %b 3",
                 credit, win, lose, state_dbg, m_credit, won, !won);
      end
      ok = 1;
      btn_inc = 1;
      repeat (S - 1) begin
        tick;
        if (win !== won || lose !== !won || state_dbg !== 3'd3) ok = 0;
      end
      btn_inc = 0;
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL show_hold: win=%b lose=%b st=%0d, required %b %b 3", win, lose, state_dbg, won, !won);
      end
      tick;
      n_chk++;
      if (win !== 1'b0 || lose !== 1'b0 || state_dbg !== (m_credit < 10 ? 3'd4 : 3'd0)
          || game_over !== (m_credit < 10) || bet_units !== 4'(m_units)) begin
        n_fail++;
        $display("FAIL show_end: win=%b lose=%b st=%0d over=%b units=%0d, required 0 0 %0d %b %0d",
                 win, lose, state_dbg, game_over, bet_units, m_credit < 10 ? 4 : 0, m_credit < 10, m_units);
      end
    end
  endtask

  task automatic restart;
    press(1, 0, 0);
    m_credit = 100;
    m_units = 1;
    n_chk++;
    if (credit !== 10'd100 || bet_units !== 4'd1 || state_dbg !== 3'd0 || game_over !== 1'b0 || start_spin !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: credit=%0d units=%0d st=%0d over=%b spin=%b, required 100 1 0 0 0",
               credit, bet_units, state_dbg, game_over, start_spin);
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_chk++;
    if (credit !== 10'd100 || bet_units !== 4'd1 || locked_pos !== 3'd0 || state_dbg !== 3'd0
        || {start_spin, win, lose, reject, err_timeout, game_over} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset: credit=%0d units=%0d pos=%0d st=%0d flags=%b, required 100 1 0 0 000000",
               credit, bet_units, locked_pos, state_dbg, {start_spin, win, lose, reject, err_timeout, game_over});
    end
  endtask

  task automatic test_win;
    do_reset;
    press(0, 1, 0);
    model_btn(1, 0);
    play(3'd3, 3'd3, 3, 0, 0);
    n_chk++;
    if (credit !== 10'd220) begin
      n_fail++;
      $display("FAIL win_credit: credit=%0d, required 220", credit);
    end
  endtask

  task automatic test_lose;
    do_reset;
    play(3'd5, 3'd2, 5, 0, 0);
    n_chk++;
    if (credit !== 10'd90) begin
      n_fail++;
      $display("FAIL lose_credit: credit=%0d, required 90", credit);
    end
  endtask

  task automatic test_reject_sat;
    do_reset;
    press(0, 1, 0);
    model_btn(1, 0);
    play(3'd1, 3'd4, 2, 0, 0);
    repeat (12) press(0, 1, 0);
    m_units = 9;
    n_chk++;
    if (bet_units !== 4'd9) begin
      n_fail++;
      $display("FAIL saturate: units=%0d, required 9", bet_units);
    end
    press(1, 0, 0);
    n_chk++;
    if (reject !== 1'b1 || start_spin !== 1'b0 || credit !== 10'd80 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reject: rej=%b spin=%b credit=%0d st=%0d, required 1 0 80 0", reject, start_spin, credit, state_dbg);
    end
    tick;
    n_chk++;
    if (reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: rej=%b, required 0", reject);
    end
    press(0, 1, 1);
    n_chk++;
    if (bet_units !== 4'd9) begin
      n_fail++;
      $display("FAIL inc_dec: units=%0d, required 9", bet_units);
    end
    press(0, 0, 1);
    model_btn(0, 1);
    play(3'd6, 3'd0, 4, 0, 1);
    restart;
  endtask

  task automatic test_timeout;
    do_reset;
    play(3'd2, 3'd0, T + 1, 0, 0);
    play(3'd2, 3'd2, T, 0, 0);
  endtask

  task automatic test_game_over;
    do_reset;
    repeat (10) play(3'd7, 3'd0, 1, 0, 0);
    n_chk++;
    if (credit !== 10'd0 || game_over !== 1'b1 || state_dbg !== 3'd4) begin
      n_fail++;
      $display("FAIL game_over: credit=%0d over=%b st=%0d, required 0 1 4", credit, game_over, state_dbg);
    end
    restart;
  endtask

  task automatic test_cap;
    do_reset;
    b8_sel = 3'd0;
    b8_start = 1;
    tick;
    b8_start = 0;
    n_chk++;
    if (c8 !== 8'd240 || s8 !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_launch: credit=%0d spin=%b, required 240 1", c8, s8);
    end
    b8_done = 1;
    b8_res = 3'd0;
    tick;
    b8_done = 0;
    tick;
    n_chk++;
    if (c8 !== 8'd255 || w8 !== 1'b1) begin
      n_fail++;
      $display("FAIL cap: credit=%0d win=%b, required 255 1", c8, w8);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bet_sel = 3'd1;
    press(1, 0, 0);
    m_spins++;
    repeat (3) tick;
    rst = 1;
    #1;
    n_chk++;
    if (credit !== 10'd100 || state_dbg !== 3'd0 || locked_pos !== 3'd0
        || {start_spin, win, lose, reject, err_timeout, game_over} !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_wait: credit=%0d st=%0d pos=%0d, required 100 0 0", credit, state_dbg, locked_pos);
    end
    tick;
    rst = 0;
    tick;
    spin_done = 1;
    result_pos = 3'd1;
    tick;
    spin_done = 0;
    n_chk++;
    if (state_dbg !== 3'd0 || credit !== 10'd100) begin
      n_fail++;
      $display("FAIL late_done: st=%0d credit=%0d, required 0 100", state_dbg, credit);
    end
    bet_sel = 3'd4;
    press(1, 0, 0);
    m_spins++;
    spin_done = 1;
    result_pos = 3'd4;
    tick;
    spin_done = 0;
    repeat (3) tick;
    rst = 1;
    #1;
    n_chk++;
    if (credit !== 10'd100 || state_dbg !== 3'd0 || win !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_show: credit=%0d st=%0d win=%b, required 100 0 0", credit, state_dbg, win);
    end
    tick;
    rst = 0;
    tick;
    m_credit = 100;
    m_units = 1;
  endtask

  task automatic test_random;
    bit i, d;
    logic [2:0] sel, res;
    do_reset;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        i = 1'($urandom);
        d = 1'($urandom);
        press(0, i, d);
        model_btn(i, d);
      end
      n_chk++;
      if (bet_units !== 4'(m_units)) begin
        n_fail++;
        $display("FAIL rnd_units: units=%0d, required %0d", bet_units, m_units);
      end
      if (m_units * 10 > m_credit) begin
        press(1, 0, 0);
        n_chk++;
        if (reject !== 1'b1 || start_spin !== 1'b0 || credit !== 10'(m_credit)) begin
          n_fail++;
          $display("FAIL rnd_reject: rej=%b spin=%b credit=%0d, required 1 0 %0d", reject, start_spin, credit, m_credit);
        end
        m_units = 1;
        repeat (9) press(0, 0, 1);
      end else begin
        sel = 3'($urandom);
        res = ($urandom % 3 == 0) ? sel : 3'($urandom);
        play(sel, res, $urandom_range(1, T + 2), 1'($urandom), 1'($urandom));
        if (m_credit < 10) restart;
      end
    end
  endtask

  initial begin
    test_reset;
    test_win;
    test_lose;
    test_reject_sat;
    test_timeout;
    test_game_over;
    test_cap;
    test_reset_mid;
    test_random;
    n_chk++;
    if (spins !== m_spins) begin
      n_fail++;
      $display("FAIL spin_count: pulses=%0d, required %0d", spins, m_spins);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
